// File: rtl/peripheral_slave_apb4_regfile_pkg.sv
// Shared definitions for the APB4 register-file slave: FSM states,
// default ID constant and the width of the wait-state counter.
package peripheral_apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_t;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B4_0001;

    // Holds WAIT_STATES-1 for WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/peripheral_slave_apb4_regfile_if.sv
// APB4 bus bundle between a master and the register-file slave.
interface peripheral_slave_apb4_regfile_if #(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic [PADDR_SIZE-1:0]     PADDR;
    logic                      PWRITE;
    logic [PDATA_SIZE/8-1:0]   PSTRB;
    logic [PDATA_SIZE-1:0]     PWDATA;
    logic [PDATA_SIZE-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/peripheral_slave_apb4_regfile_regfile.sv
// Register storage: byte-enabled synchronous write port, combinational read.
module peripheral_regfile_apb4 #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
    input  logic [DATA_W/8-1:0]         wr_strb,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
    output logic [DATA_W-1:0]           rd_data
);
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Clear on reset, otherwise update only the strobed bytes of one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/peripheral_slave_apb4_regfile.sv
// APB4 slave with a small register file; register 0 is a read-only ID.
// Each transfer is stretched by WAIT_STATES cycles before PREADY.
module peripheral_slave_apb4_regfile
    import peripheral_apb4_pkg::*;
#(
    parameter int                    PADDR_SIZE  = 16,
    parameter int                    PDATA_SIZE  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 1,
    parameter logic [PDATA_SIZE-1:0] ID_VALUE    = PDATA_SIZE'(ID_VALUE_DEFAULT)
) (
    input logic                      PCLK,
    input logic                      PRESET,
    peripheral_slave_apb4_regfile_if.slave apb
);
    localparam int                  IDX_W      = $clog2(NUM_REGS);
    localparam logic [PADDR_SIZE:0] ADDR_LIMIT = (PADDR_SIZE+1)'(NUM_REGS * 4);

    apb_state_t             state, state_next;
    logic [WAIT_CNT_W-1:0]  cnt, cnt_next;
    logic [IDX_W-1:0]       idx;
    logic                   addr_err;
    logic                   wr_en;
    logic [PDATA_SIZE-1:0]  rd_word;
    logic [PDATA_SIZE-1:0]  prdata_q;
    logic                   pslverr_q;

    assign idx      = apb.PADDR[IDX_W+1:2];
    // Register 0 is read-only; writing it is reported as an error.
    assign addr_err = ({1'b0, apb.PADDR} >= ADDR_LIMIT) ||
                      (apb.PADDR[1:0] != 2'b00) ||
                      (apb.PWRITE && (idx == '0));

    // Next-state logic; a dropped PSEL during WAIT abandons the transfer.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt - WAIT_CNT_W'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter and response registers; response is captured entering DONE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state_next == ST_DONE) begin
                pslverr_q <= addr_err;
                if (addr_err || apb.PWRITE) begin
                    prdata_q <= '0;
                end else if (idx == '0) begin
                    prdata_q <= ID_VALUE;
                end else begin
                    prdata_q <= rd_word;
                end
            end else begin
                prdata_q  <= '0;
                pslverr_q <= 1'b0;
            end
        end
    end

    assign wr_en = (state == ST_DONE) && apb.PSEL && apb.PENABLE &&
                   apb.PWRITE && !addr_err && !PRESET;

    peripheral_regfile_apb4 #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (PDATA_SIZE)
    ) u_regs (
        .clk     (PCLK),
        .rst     (PRESET),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_strb (apb.PSTRB),
        .wr_data (apb.PWDATA),
        .rd_idx  (idx),
        .rd_data (rd_word)
    );

    assign apb.PREADY  = (state == ST_DONE);
    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;

endmodule

// File: doc/peripheral_slave_apb4_regfile.md
PERIPHERAL_SLAVE_APB4_REGFILE -- requirements
Module: peripheral_slave_apb4_regfile

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 16, APB address width.
REQ-002 SHALL have parameter PDATA_SIZE, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter NUM_REGS, default 16, register count (power of 2, >=2).
REQ-004 SHALL have parameter WAIT_STATES, default 1, wait cycles inserted per transfer (0..15).
REQ-005 SHALL have parameter ID_VALUE, default 32'hA5B4_0001, constant returned by register 0.
REQ-006 SHALL have one clock and one reset: PCLK is the single clock; PRESET is synchronous, active-high.
REQ-007 PCLK  input  1  clock; all logic on rising edge.
REQ-008 PRESET  input  1  synchronous active-high reset.
REQ-009 PSEL  input  1  slave select.
REQ-010 PENABLE  input  1  access phase.
REQ-011 PADDR  input  PADDR_SIZE  byte address.
REQ-012 PWRITE  input  1  1=write, 0=read.
REQ-013 PSTRB  input  PDATA_SIZE/8  write byte enables.
REQ-014 PWDATA  input  PDATA_SIZE  write data.
REQ-015 PRDATA  output  PDATA_SIZE  read data, valid only while PREADY=1.
REQ-016 PREADY  output  1  transfer completion.
REQ-017 PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-018 FSM states IDLE, WAIT, DONE; PREADY SHALL be registered and equal (state==DONE).
REQ-019 IDLE: on PSEL=1 & PENABLE=0 (setup) SHALL go to DONE if WAIT_STATES=0, else WAIT with counter=WAIT_STATES-1.
REQ-020 WAIT: counter==0 -> DONE; else decrement; PSEL=0 (master abandon) -> IDLE, no register change.
REQ-021 DONE: SHALL last exactly one cycle, then IDLE; access phase thus lasts WAIT_STATES+1 cycles.
REQ-022 Decode: word index = PADDR[log2(NUM_REGS)+1:2]; error if PADDR >= NUM_REGS*4 or PADDR[1:0]!=0 or write to register 0.
REQ-023 PRDATA and PSLVERR SHALL be registered on the transition into DONE; PRDATA=0 outside DONE and on error; PSLVERR=0 outside DONE.
REQ-024 Read of register 0 SHALL return ID_VALUE; other registers return stored contents.
REQ-025 Write SHALL commit on the rising edge ending DONE, only if PSEL&PENABLE&PWRITE and no error, updating only bytes with PSTRB bit set.
REQ-026 Errored writes SHALL leave all registers unchanged; errored reads SHALL not alter state.
REQ-027 Back-to-back transfers: a setup phase seen in IDLE directly after DONE SHALL be accepted with no extra idle cycle.
REQ-028 Read data SHALL reflect all writes completed in earlier transfers.

Reset
REQ-029 On PCLK edge with PRESET=1: state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, registers 1..NUM_REGS-1 =0.
REQ-030 PRESET asserted mid-transfer SHALL abort it with no register write; PRESET SHALL dominate all other inputs.

Structure
REQ-031 Shared package peripheral_apb4_pkg SHALL hold the FSM state enum, ID_VALUE default and wait-counter width constant.
REQ-032 Storage SHALL be one sub-module peripheral_regfile_apb4 (byte-enabled write port, combinational read port); FSM/decode in top.

Verification
REQ-033 Reset, then read 0x0000 -> PREADY after 2 access cycles (WAIT_STATES=1), PRDATA=32'hA5B4_0001, PSLVERR=0.
REQ-034 Write 0x0004 data 32'hDEADBEEF PSTRB=4'b0101, then read 0x0004 -> 32'h00AD00EF, PSLVERR=0.
REQ-035 Write 0x0000 data 32'h12345678 -> PSLVERR=1; read 0x0000 -> still 32'hA5B4_0001.
REQ-036 Read 0x0040 and 0x0006 (NUM_REGS=16) -> PSLVERR=1, PRDATA=0.
REQ-037 Assert PRESET during WAIT of write 0x0008 data 32'hFFFFFFFF -> PREADY=0 next cycle; read 0x0008 -> 0.
REQ-038 WAIT_STATES=0, back-to-back write 0x000C 32'h1, read 0x000C -> each PREADY in first access cycle, read 32'h1.
